// File: rtl/req_gnt_arbiter_if.sv
// Request/grant bus between four requesters and req_gnt_arbiter.
// master: requester side (drives req); slave: arbiter side.
interface req_gnt_arbiter_if;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       busy;
  logic [3:0] wait_err;

  modport master (
    output req,
    input  gnt,
    input  gnt_id,
    input  busy,
    input  wait_err
  );

  modport slave (
    input  req,
    output gnt,
    output gnt_id,
    output busy,
    output wait_err
  );
endinterface

// File: rtl/req_gnt_arbiter.sv
// Four-way round-robin request/grant arbiter with registered one-hot grant,
// bounded hold time and a one-cycle bubble after every release.
// Optional feature: define REQ_GNT_WAIT_CHECK_EN to build per-requester
// wait counters and sticky wait_err flags; otherwise wait_err is tied low.
module req_gnt_arbiter #(
  parameter int unsigned MAX_HOLD   = 4,
  parameter int unsigned WAIT_LIMIT = 5
) (
  input  logic                clk,
  input  logic                rst,
  req_gnt_arbiter_if.slave    arb
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  localparam logic [3:0] LP_MAX_HOLD   = 4'(MAX_HOLD);
  localparam logic [3:0] LP_WAIT_LIMIT = 4'(WAIT_LIMIT);

  // Reject out-of-range configurations at elaboration.
  if (MAX_HOLD < 1 || MAX_HOLD > 15) begin : g_bad_max_hold
    $error("req_gnt_arbiter: MAX_HOLD must be 1..15");
  end
  if (WAIT_LIMIT < 1 || WAIT_LIMIT > 15) begin : g_bad_wait_limit
    $error("req_gnt_arbiter: WAIT_LIMIT must be 1..15");
  end

  state_t     r_state;
  state_t     w_state_nxt;
  logic [3:0] r_gnt;
  logic [3:0] w_gnt_nxt;
  logic [1:0] r_owner;
  logic [1:0] w_owner_nxt;
  logic [1:0] r_last;
  logic [1:0] w_last_nxt;
  logic [3:0] r_hold;
  logic [3:0] w_hold_nxt;

  logic       w_any_req;
  logic       w_found;
  logic [1:0] w_cand;
  logic [1:0] w_winner;
  logic [3:0] w_hold_inc;
  logic       w_release;

  assign w_any_req  = |arb.req;
  assign w_hold_inc = (r_hold == 4'hF) ? r_hold : r_hold + 4'd1;
  // Owner dropping req and the hold limit can coincide; either one (or both)
  // produces the same single release.
  assign w_release  = !arb.req[r_owner] || (w_hold_inc >= LP_MAX_HOLD);

  // Round-robin pick: first requester at or after last_owner+1 (mod 4).
  always_comb begin
    w_winner = r_last;
    w_found  = 1'b0;
    w_cand   = r_last;
    for (int unsigned off = 1; off <= 4; off++) begin
      w_cand = 2'(32'(r_last) + off);
      if (!w_found && arb.req[w_cand]) begin
        w_winner = w_cand;
        w_found  = 1'b1;
      end
    end
  end

  // State and grant registers; reset drops any grant immediately.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_gnt   <= '0;
      r_owner <= '0;
      r_last  <= 2'd3;
      r_hold  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_gnt   <= w_gnt_nxt;
      r_owner <= w_owner_nxt;
      r_last  <= w_last_nxt;
      r_hold  <= w_hold_nxt;
    end
  end

  // Next-state, next-grant and hold-counter logic.
  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = r_gnt;
    w_owner_nxt = r_owner;
    w_last_nxt  = r_last;
    w_hold_nxt  = r_hold;
    case (r_state)
      S_IDLE, S_GAP: begin
        if (w_any_req) begin
          w_state_nxt = S_GRANT;
          w_gnt_nxt   = 4'b0001 << w_winner;
          w_owner_nxt = w_winner;
          w_last_nxt  = w_winner;
          w_hold_nxt  = '0;
        end else begin
          w_state_nxt = S_IDLE;
          w_gnt_nxt   = '0;
          w_owner_nxt = '0;
        end
      end
      S_GRANT: begin
        if (w_release) begin
          w_state_nxt = S_GAP;
          w_gnt_nxt   = '0;
          w_owner_nxt = '0;
        end else begin
          w_hold_nxt  = w_hold_inc;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_gnt_nxt   = '0;
        w_owner_nxt = '0;
        w_hold_nxt  = '0;
      end
    endcase
  end

  assign arb.gnt    = r_gnt;
  assign arb.gnt_id = r_owner;
  assign arb.busy   = |r_gnt;

`ifdef REQ_GNT_WAIT_CHECK_EN
  logic [3:0] r_wait_cnt [4];
  logic [3:0] w_wait_cnt_nxt [4];
  logic [3:0] r_wait_err;
  logic [3:0] w_wait_err_nxt;

  // Per-requester wait counters; flags are sticky until reset.
  always_comb begin
    w_wait_err_nxt = r_wait_err;
    for (int unsigned i = 0; i < 4; i++) begin
      if (arb.req[i] && !r_gnt[i]) begin
        w_wait_cnt_nxt[i] = (r_wait_cnt[i] == 4'hF) ? r_wait_cnt[i]
                                                    : r_wait_cnt[i] + 4'd1;
        if (w_wait_cnt_nxt[i] >= LP_WAIT_LIMIT) begin
          w_wait_err_nxt[i] = 1'b1;
        end
      end else begin
        w_wait_cnt_nxt[i] = '0;
      end
    end
  end

  // Wait counter and error flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < 4; i++) begin
        r_wait_cnt[i] <= '0;
      end
      r_wait_err <= '0;
    end else begin
      for (int unsigned i = 0; i < 4; i++) begin
        r_wait_cnt[i] <= w_wait_cnt_nxt[i];
      end
      r_wait_err <= w_wait_err_nxt;
    end
  end

  assign arb.wait_err = r_wait_err;
`else
  assign arb.wait_err = '0;
`endif

endmodule

// File: doc/req_gnt_arbiter.md
REQ_GNT_ARBITER -- requirements
Module: req_gnt_arbiter

Interface
REQ-001 Parameter MAX_HOLD, default 4, SHALL set the maximum consecutive cycles one grant is held (legal 1..15).
REQ-002 Parameter WAIT_LIMIT, default 5, SHALL set the cycles a pending request may wait before being flagged (legal 1..15).
REQ-003 clk  input  1  single rising-edge clock for all state.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 req  input  4  per-requester request level; held high while access is wanted.
REQ-006 gnt  output  4  one-hot grant, registered; all-zero when nobody is granted.
REQ-007 gnt_id  output  2  index of the current grant owner; 0 when gnt is zero.
REQ-008 busy  output  1  high while any gnt bit is high.
REQ-009 wait_err  output  4  sticky per-requester latency-violation flags.

Function
REQ-010 The FSM SHALL have three states: IDLE (no grant), GRANT (one owner), GAP (one-cycle bubble after a release).
- IDLE or GAP, req != 0 at edge k: move to GRANT; the winner's gnt bit is high from edge k.
- IDLE or GAP, req == 0: go to or stay in IDLE.
- GRANT: release when the owner's req is sampled low, or when the hold counter reaches MAX_HOLD; then go to GAP with gnt = 0.
REQ-011 The winner SHALL be chosen round-robin: search starts at last_owner+1 mod 4; last_owner updates on every grant.
REQ-012 With an idle arbiter, a request sampled at edge k SHALL see its grant at edge k, a 1-cycle req-to-gnt latency.
REQ-013 The hold counter SHALL clear on every new grant, increment each GRANT cycle, and saturate; no grant exceeds MAX_HOLD cycles.
REQ-014 If the owner's req drops in the same cycle the hold limit is reached, there SHALL be exactly one release and one GAP cycle.
REQ-015 GAP SHALL always last exactly one cycle; the same requester may win again after GAP only if no other req is high.
REQ-016 gnt SHALL never have more than one bit set, and SHALL never be set for a requester whose req was low at the granting edge.
REQ-017 Changes in req of non-owners during GRANT SHALL NOT affect the current grant.

Reset
REQ-018 At the first rising clk edge with rst=1, the block SHALL apply these values regardless of state:
- gnt=0, gnt_id=0, busy=0, wait_err=0
- state=IDLE, hold counter=0, wait counters=0
- last_owner=3, so requester 0 has first priority.
REQ-019 A reset during GRANT SHALL drop gnt at that edge, with no GAP cycle.
REQ-020 req SHALL be ignored while rst=1.

Configuration
REQ-021 With macro REQ_GNT_WAIT_CHECK_EN defined, a 4-bit wait counter SHALL exist per requester.
- It counts cycles with req[i]=1 and gnt[i]=0.
- It clears when req[i]=0 or gnt[i]=1.
- When it reaches WAIT_LIMIT, wait_err[i] SHALL set and stay set until rst.
REQ-022 Without REQ_GNT_WAIT_CHECK_EN, the wait counters SHALL NOT be built and wait_err SHALL be tied to 0.

Verification
REQ-023 Scenario 1: after reset, req=0001 at edge 3 -> gnt=0001 and gnt_id=0 at edge 3; busy=1.
REQ-024 Scenario 2: req=0001 held 10 cycles, MAX_HOLD=4 -> gnt high 4 cycles, 0 for 1 GAP cycle, then regranted; the pattern repeats.
REQ-025 Scenario 3: req=1111 held -> grant order 0,1,2,3,0, each owner held 4 cycles with 1-cycle gaps; gnt is always one-hot.
REQ-026 Scenario 4: requester 2 owns the bus and drops req on the cycle its hold count reaches 4 -> single release and one GAP cycle; then IDLE if req=0.
REQ-027 Scenario 5: rst asserted mid-GRANT with owner 1 -> gnt=0 at that edge; after rst, req=0011 -> requester 0 granted first.
REQ-028 Scenario 6 (macro defined): req=0011 held -> requester 1 waits 5 cycles -> wait_err=0010, still set after req drops; cleared only by rst.
